// File: rtl/ingress_frame_writer.sv
// Pops completed frames from IngressCDC, reserves space in the circular packet
// buffer, writes the data words and emits one descriptor per committed frame.
module ingress_frame_writer #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 11,
  parameter int MAX_BYTES  = 1522
) (
  input  logic                  clk_mem,
  input  logic                  rst_n,
  input  logic                  mem_frame_ready,
  output logic                  mem_frame_start,
  input  logic [LEN_WIDTH-1:0]  mem_frame_bytelen,
  input  logic [11:0]           mem_frame_vlan,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_frame_done,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [ADDR_WIDTH-1:0] desc_addr,
  output logic [LEN_WIDTH-1:0]  desc_bytelen,
  output logic [11:0]           desc_vlan,
  input  logic                  release_valid,
  input  logic [ADDR_WIDTH:0]   release_words,
  output logic [ADDR_WIDTH:0]   free_words,
  output logic [15:0]           drop_count
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int BSH = $clog2(BPW);
  localparam int CW  = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]        DEPTH = CW'(1) << ADDR_WIDTH;
  localparam logic [LEN_WIDTH:0]   MAX_L = (LEN_WIDTH+1)'(MAX_BYTES);
  localparam logic [LEN_WIDTH:0]   RND   = (LEN_WIDTH+1)'(BPW - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t                state;
  logic                  cool;
  logic [ADDR_WIDTH-1:0] wr_ptr, start_addr;
  logic [CW-1:0]         used, words_q, written;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [11:0]           vlan_q;

  logic [LEN_WIDTH:0]    len_round;
  logic [CW-1:0]         words_in;
  logic                  accept, take_word, commit;
  logic [CW:0]           used_add, rel_ext;
  logic [CW-1:0]         used_next;

  assign len_round = {1'b0, mem_frame_bytelen} + RND;
  assign words_in  = CW'(len_round >> BSH);

  // Pop is combinational so the length/vlan are latched in the same cycle;
  // cool blocks the cycle IDLE is re-entered so a done never abuts a start.
  assign mem_frame_start = rst_n && (state == IDLE) && !cool && mem_frame_ready;

  assign accept = (mem_frame_bytelen != '0) && ({1'b0, mem_frame_bytelen} <= MAX_L) &&
                  (words_in <= free_words) && !desc_valid;

  assign take_word = (state == WRITE) && mem_valid && (written < words_q);
  assign commit    = (state == WRITE) && mem_frame_done;

  // Commit and release in one cycle apply the net; over-release clamps at zero.
  assign used_add = {1'b0, used} + (commit ? {1'b0, words_q} : '0);
  assign rel_ext  = {1'b0, release_words};
  always_comb begin
    used_next = CW'(used_add);
    if (release_valid)
      used_next = (used_add > rel_ext) ? CW'(used_add - rel_ext) : '0;
  end

  always_ff @(posedge clk_mem) begin
    if (!rst_n) begin
      state        <= IDLE;
      cool         <= 1'b0;
      wr_ptr       <= '0;
      start_addr   <= '0;
      used         <= '0;
      free_words   <= DEPTH;
      words_q      <= '0;
      written      <= '0;
      len_q        <= '0;
      vlan_q       <= '0;
      buf_wr_en    <= 1'b0;
      buf_wr_addr  <= '0;
      buf_wr_data  <= '0;
      desc_valid   <= 1'b0;
      desc_addr    <= '0;
      desc_bytelen <= '0;
      desc_vlan    <= '0;
      drop_count   <= '0;
    end else begin
      buf_wr_en  <= 1'b0;
      cool       <= 1'b0;
      used       <= used_next;
      free_words <= DEPTH - used_next;
      if (desc_valid && desc_ready)
        desc_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (mem_frame_start) begin
            len_q      <= mem_frame_bytelen;
            vlan_q     <= mem_frame_vlan;
            words_q    <= words_in;
            start_addr <= wr_ptr;
            written    <= '0;
            if (accept) begin
              state <= WRITE;
            end else begin
              state <= DROP;
              if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            end
          end
        end
        WRITE: begin
          if (take_word) begin
            buf_wr_en   <= 1'b1;
            buf_wr_addr <= wr_ptr;
            buf_wr_data <= mem_data;
            wr_ptr      <= wr_ptr + 1'b1;
            written     <= written + 1'b1;
          end
          // Short frames still consume their whole reservation.
          if (commit) begin
            wr_ptr       <= start_addr + words_q[ADDR_WIDTH-1:0];
            desc_valid   <= 1'b1;
            desc_addr    <= start_addr;
            desc_bytelen <= len_q;
            desc_vlan    <= vlan_q;
            state        <= IDLE;
            cool         <= 1'b1;
          end
        end
        DROP: begin
          if (mem_frame_done) begin
            state <= IDLE;
            cool  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ingress_frame_writer.md
Name: ingress_frame_writer

Overview:
Sits directly downstream of IngressCDC, in the clk_mem domain. Pops frames IngressCDC has completed, reserves space in a circular packet buffer, and writes the frame's data words to the buffer. On frame completion it emits one descriptor (start address, byte length, VLAN) to the forwarding engine. Frames that do not fit, or that arrive while the descriptor slot is busy, are drained and counted as drops.

Parameters:
DATA_WIDTH, 128, width of mem_data and buffer words (bytes per word = DATA_WIDTH/8)
ADDR_WIDTH, 12, buffer word address width; depth = 2^ADDR_WIDTH words
LEN_WIDTH, 11, frame byte length width
MAX_BYTES, 1522, largest frame accepted (bytes)

Ports:
clk_mem  in  1  memory-domain clock
rst_n  in  1  synchronous reset, active low
mem_frame_ready  in  1  IngressCDC has a complete frame pending
mem_frame_start  out  1  one-cycle pop strobe to IngressCDC
mem_frame_bytelen  in  LEN_WIDTH  pending frame length; valid while mem_frame_ready
mem_frame_vlan  in  12  pending frame VLAN; valid while mem_frame_ready
mem_valid  in  1  mem_data word valid
mem_data  in  DATA_WIDTH  frame data word
mem_frame_done  in  1  one-cycle end of frame; may coincide with the last mem_valid
buf_wr_en  out  1  buffer write strobe
buf_wr_addr  out  ADDR_WIDTH  buffer write address
buf_wr_data  out  DATA_WIDTH  buffer write data
desc_valid  out  1  descriptor available
desc_ready  in  1  downstream accepts descriptor
desc_addr  out  ADDR_WIDTH  first word address of frame
desc_bytelen  out  LEN_WIDTH  frame length
desc_vlan  out  12  frame VLAN
release_valid  in  1  downstream frees the oldest committed frame
release_words  in  ADDR_WIDTH+1  word count being freed
free_words  out  ADDR_WIDTH+1  unreserved buffer words
drop_count  out  16  saturating count of dropped frames

Behaviour:
- Interface: one clock, clk_mem. Reset rst_n is synchronous and active-low.
- Reset values:
  - FSM = IDLE.
  - wr_ptr = 0, used = 0, so free_words = 2^ADDR_WIDTH.
  - mem_frame_start = 0, buf_wr_en = 0, desc_valid = 0, drop_count = 0.
  - desc_addr, desc_bytelen, desc_vlan, buf_wr_addr, buf_wr_data = 0.
- Reset mid-frame: everything is abandoned. Stray mem_valid or mem_frame_done seen in IDLE is ignored.
- Word count: words = ceil(bytelen / (DATA_WIDTH/8)), computed as (bytelen + 15) >> 4 for the default width.
- IDLE:
  - When mem_frame_ready=1, assert mem_frame_start for exactly that cycle.
  - In the same cycle, latch bytelen, vlan and words, and set start_addr = wr_ptr.
  - Accept if all of: bytelen != 0, bytelen <= MAX_BYTES, words <= free_words, desc_valid == 0. Accepted frames go to WRITE.
  - Otherwise go to DROP and increment drop_count (saturating at 0xFFFF).
- WRITE:
  - Each mem_valid with written < words: buf_wr_en=1, buf_wr_addr=wr_ptr, buf_wr_data=mem_data (registered, 1-cycle latency). Then wr_ptr increments mod 2^ADDR_WIDTH (wraps from 0xFFF to 0) and written increments.
  - Words beyond the reservation are not written.
  - On mem_frame_done (after handling any coincident word):
    - used += words.
    - Next cycle: desc_valid=1, desc_addr=start_addr, desc_bytelen and desc_vlan as latched.
    - Return to IDLE.
    - If written < words at done, wr_ptr is still advanced to start_addr + words, so the descriptor span stays exact.
- DROP:
  - No buffer writes; mem_valid words are discarded.
  - mem_frame_done returns to IDLE; wr_ptr and used are unchanged.
- IDLE does not assert mem_frame_start in the cycle it is entered from WRITE or DROP, so there is at least one cycle between a done and the next start.
- Descriptor handshake:
  - desc_valid holds, with fields stable, until desc_valid & desc_ready. It clears the following cycle.
  - desc_ready is ignored while desc_valid=0.
- Release:
  - release_valid subtracts release_words from used.
  - A commit and a release in the same cycle apply the net: used + words - release_words.
  - A release exceeding used clamps used to 0.
- free_words = 2^ADDR_WIDTH - used, registered. A reservation counts as used only at commit; the frame in progress never exceeds its reservation, so there is no overflow.

Test Plan:
1. Reset, then a 64-byte frame (4 words) with vlan 3 -> one mem_frame_start pulse; buf_wr_addr 0..3; desc_valid with desc_addr=0, desc_bytelen=64, desc_vlan=3; free_words=4092.
2. wr_ptr preset to 4094 by earlier traffic, then a 60-byte frame -> writes at 4094, 4095, 0, 1; desc_addr=4094.
3. used=4090, then a 128-byte frame (8 words) -> drop, drop_count=1, no buf_wr_en; next 64-byte frame accepted (4 <= 6).
4. desc_ready held low after frame A, then frame B arrives -> B dropped. Then desc_ready=1 -> handshake completes; frame C accepted with desc_addr following A's span.
5. release_valid with release_words=4 in the same cycle as a 5-word commit, from used=10 -> used=11, free_words=4085.
6. rst_n low during WRITE after 2 of 6 words -> all outputs at reset values next cycle; subsequent frame written starting at address 0.
